// File: rtl/vm_pkg.sv
// Coin codes and acceptor state encoding. Also imported by vending_machine,
// so the coin code values here are the contract between the two blocks.
package vm_pkg;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;
  localparam logic [1:0] COIN_BOTH   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    EMIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // True for the two codes that may be forwarded to vending_machine.
  function automatic logic is_single_coin(input logic [1:0] code);
    return (code == COIN_NICKEL) || (code == COIN_DIME);
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Two-flop synchronizer for one asynchronous sensor line.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic q1_q;
  logic q2_q;

  // Shift the raw line through two flops to settle metastability.
  // NOTE: non-blocking assignments make q2_q take the old q1_q, giving a true
  // two-stage shift; blocking here would collapse it into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the nickel/dime sensors,
// emits one single-cycle coin code (or reject pulse) per physical coin, and
// locks out further codes until the slot has been seen empty long enough.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       nickel_sense,
  input  logic       dime_sense,
  output logic [1:0] coin,
  output logic       reject,
  output logic       busy,
  output logic [7:0] accept_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       nickel_s;
  logic       dime_s;
  logic [1:0] s;

  state_e     state_q,  state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] cand_q,   cand_d;
  logic [1:0] coin_q,   coin_d;
  logic       reject_q, reject_d;
  logic       busy_q,   busy_d;
  logic [7:0] acc_q,    acc_d;

  sync2 u_sync_nickel (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (nickel_sense),
    .q_o   (nickel_s)
  );

  sync2 u_sync_dime (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (dime_sense),
    .q_o   (dime_s)
  );

  assign s = {dime_s, nickel_s};

  // Next-state and registered-output decode for the debounce/lockout FSM.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    coin_d   = COIN_NONE;
    reject_d = 1'b0;
    acc_d    = acc_q;

    unique case (state_q)
      IDLE: begin
        if (en && (s != COIN_NONE)) begin
          cand_d  = s;
          cnt_d   = CNT_ONE;
          state_d = QUALIFY;
        end
      end

      QUALIFY: begin
        if (s == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = EMIT;
            if (is_single_coin(cand_q)) begin
              coin_d = cand_q;
              acc_d  = acc_q + 8'd1;
            end else begin
              reject_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (s == COIN_NONE) begin
          // Sensor dropped before qualifying: treat as a glitch.
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          // Sensor pattern changed to another nonzero value: restart on it.
          cand_d = s;
          cnt_d  = CNT_ONE;
        end
      end

      EMIT: begin
        cnt_d   = CNT_ZERO;
        state_d = RELEASE;
      end

      RELEASE: begin
        if (s == COIN_NONE) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Coin still (or again) in the slot: release must start over.
          cnt_d = CNT_ZERO;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // busy is registered from the next state so it lines up with state_q.
  always_comb begin
    busy_d = (state_d != IDLE);
  end

  // FSM state, debounce counter, candidate and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      cand_q   <= COIN_NONE;
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      acc_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
    end
  end

  assign coin       = coin_q;
  assign reject     = reject_q;
  assign busy       = busy_q;
  assign accept_cnt = acc_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: a fixed table for the clean-coin and
// both-sensor cases, hand sequences for bounce/lockout/reset/wrap/enable, and
// randomized stimulus, all compared against a run-length reference model.
module tb_coin_acceptor;
  import vm_pkg::*;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       nickel_sense;
  logic       dime_sense;
  logic [1:0] coin;
  logic       reject;
  logic       busy;
  logic [7:0] accept_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int pulses     = 0;

  always #1000 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .nickel_sense (nickel_sense),
    .dime_sense   (dime_sense),
    .coin         (coin),
    .reject       (reject),
    .busy         (busy),
    .accept_cnt   (accept_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expresses the rules as run lengths of identical synchronized samples:
  // an accepted coin needs DC equal nonzero samples (counting from the first
  // one seen with en high), then one output cycle, then DC empty samples.
  bit [1:0] m_p1, m_p2;     // two-cycle sensor delay
  bit       m_armed;        // may accept a new coin
  bit       m_dead;         // the cycle after an output
  bit [1:0] m_cand;
  int       m_run;
  bit [1:0] m_coin;
  bit       m_rej;
  bit [7:0] m_acc;

  task automatic model_reset();
    m_p1 = 2'b00; m_p2 = 2'b00;
    m_armed = 1'b1; m_dead = 1'b0;
    m_cand = 2'b00; m_run = 0;
    m_coin = 2'b00; m_rej = 1'b0; m_acc = 8'd0;
  endtask

  function automatic bit m_busy();
    return !(m_armed && (m_run == 0) && !m_dead);
  endfunction

  task automatic model_edge(input bit n, input bit d, input bit e);
    bit [1:0] smp;
    smp  = m_p2;
    m_p2 = m_p1;
    m_p1 = {d, n};
    m_coin = 2'b00;
    m_rej  = 1'b0;
    if (m_dead) begin
      m_dead = 1'b0;
      m_run  = 0;
    end else if (m_armed) begin
      if (m_run == 0) begin
        if (e && smp != 2'b00) begin
          m_cand = smp;
          m_run  = 1;
        end
      end else if (smp == m_cand) begin
        m_run++;
        if (m_run == DC) begin
          if (smp == 2'b11) m_rej = 1'b1;
          else begin
            m_coin = smp;
            m_acc  = m_acc + 8'd1;
          end
          m_armed = 1'b0;
          m_dead  = 1'b1;
          m_run   = 0;
        end
      end else if (smp == 2'b00) begin
        m_run = 0;
      end else begin
        m_cand = smp;
        m_run  = 1;
      end
    end else begin
      if (smp == 2'b00) begin
        m_run++;
        if (m_run == DC) begin
          m_armed = 1'b1;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare at the falling edge.
  task automatic step(input bit n, input bit d, input bit e);
    nickel_sense = n;
    dime_sense   = d;
    en           = e;
    @(posedge clk);
    model_edge(n, d, e);
    @(negedge clk);
    check("model {coin,reject,busy,acc}", 32'({coin, reject, busy, accept_cnt}),
          32'({m_coin, m_rej, m_busy(), m_acc}));
    check("legal coin/reject", 32'((coin == 2'b11) || (coin != 2'b00 && reject)), 32'd0);
    if (coin != 2'b00 || reject) pulses++;
  endtask

  typedef struct {
    bit       n, d, e;
    bit [1:0] coin;
    bit       rej, busy;
    bit [7:0] acc;
  } vec_t;

  vec_t tbl[50];

  initial begin
    // Table: clean nickel (20 high, 10 low), then both sensors (10 high, 10 low).
    for (int i = 0; i < 50; i++) begin
      if (i < 30) begin
        tbl[i].n = (i < 20); tbl[i].d = 1'b0; tbl[i].e = 1'b1;
        tbl[i].coin = (i == 5) ? COIN_NICKEL : COIN_NONE;
        tbl[i].rej  = 1'b0;
        tbl[i].busy = (i >= 2) && (i <= 24);
        tbl[i].acc  = (i >= 5) ? 8'd1 : 8'd0;
      end else begin
        tbl[i].n = (i - 30 < 10); tbl[i].d = (i - 30 < 10); tbl[i].e = 1'b1;
        tbl[i].coin = COIN_NONE;
        tbl[i].rej  = (i - 30 == 5);
        tbl[i].busy = (i - 30 >= 2) && (i - 30 <= 14);
        tbl[i].acc  = 8'd1;
      end
    end

    rst = 1'b0; en = 1'b0; nickel_sense = 1'b0; dime_sense = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset state", 32'({coin, reject, busy, accept_cnt}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 50; i++) begin
      step(tbl[i].n, tbl[i].d, tbl[i].e);
      check($sformatf("table[%0d]", i), 32'({coin, reject, busy, accept_cnt}),
            32'({tbl[i].coin, tbl[i].rej, tbl[i].busy, tbl[i].acc}));
    end

    // Bounce on dime, then stable high: exactly one dime code.
    pulses = 0;
    begin
      bit b[6] = '{1, 0, 1, 1, 0, 1};
      for (int i = 0; i < 6; i++) step(1'b0, b[i], 1'b1);
    end
    repeat (15) step(1'b0, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    check("bounce pulse count", 32'(pulses), 32'd1);
    check("bounce tally", 32'(accept_cnt), 32'd2);

    // Lockout: long press, short gap, re-press gives no second code.
    pulses = 0;
    repeat (40) step(1'b1, 1'b0, 1'b1);
    repeat (2)  step(1'b0, 1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    check("lockout pulse count", 32'(pulses), 32'd1);
    repeat (10) step(1'b1, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    check("rearm after release", 32'(pulses), 32'd2);

    // Reset in the middle of qualification (counter at 2).
    repeat (4) step(1'b1, 1'b0, 1'b1);
    #300;
    rst = 1'b0;
    model_reset();
    #1;
    check("async reset {coin,busy,acc}", 32'({coin, busy, accept_cnt}), 32'd0);
    nickel_sense = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (10) step(1'b0, 1'b0, 1'b1);
    check("no pulse after reset", 32'(pulses), 32'd0);

    // 256 accepted nickels wrap the tally back to 0.
    pulses = 0;
    for (int k = 0; k < 256; k++) begin
      repeat (7) step(1'b1, 1'b0, 1'b1);
      repeat (8) step(1'b0, 1'b0, 1'b1);
    end
    check("wrap pulse count", 32'(pulses), 32'd256);
    check("wrap tally", 32'(accept_cnt), 32'd0);

    // Disabled: dime held high is ignored.
    pulses = 0;
    repeat (20) step(1'b0, 1'b1, 1'b0);
    check("en=0 busy", 32'(busy), 32'd0);
    check("en=0 pulse count", 32'(pulses), 32'd0);
    repeat (4) step(1'b0, 1'b0, 1'b0);

    // Randomized sensor activity with sticky levels so coins can qualify.
    begin
      bit rn = 1'b0, rd = 1'b0, re = 1'b1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(3) == 0) begin
          rn = 1'($urandom_range(1));
          rd = ($urandom_range(3) == 0);
        end
        if ($urandom_range(15) == 0) re = ~re;
        step(rn, rd, re);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
